// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam logic [1:0] INSTR_LEN_32 = 2'b11;
   typedef enum logic {RUN, DRAIN} fetch_state_t;
   typedef struct packed {
      logic [31:2]             instr;
      logic [XLEN_DEFAULT-1:0] pc;
      logic                    illegal;
   } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory, redirect and decode-side signals of the fetch unit.
interface ifu_fetch_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [29:0]     instr_out;
   logic [XLEN-1:0] pc_out;
   logic            instr_illegal;
   modport master (
      output imem_req, imem_addr, instr_valid, instr_out, pc_out, instr_illegal,
      input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr_out, pc_out, instr_illegal,
      output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// fetch_queue: power-of-two synchronous FIFO; flush wins over push and pop.
module fetch_queue
   import ifu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  T                         din,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   T mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_comb begin
      dout = mem[rd_ptr];
      full = count == CW'(DEPTH);
      empty = count == '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential PC generation, imem request/ack, fetch queue and
// redirect handling with a DRAIN state that swallows an in-flight response.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input logic         clk,
   input logic         rst_n,
   ifu_fetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   typedef struct packed {
      logic [31:2]     instr;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } entry_t;
   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt, drain_addr;
   logic [CW-1:0]   count;
   logic            full, empty, push, pop;
   entry_t          din, head, last;
   fetch_queue #(.DEPTH(DEPTH), .T(entry_t)) queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   // drain_addr tracks pc while running so the abandoned request keeps its address in DRAIN
   always_comb begin
      bus.imem_req = rst_n && count < CW'(DEPTH);
      bus.imem_addr = state == DRAIN ? drain_addr : pc;
      push = state == RUN && !full && bus.imem_ack && !bus.redirect;
      pop = !empty && bus.instr_ready;
      din = {bus.imem_rdata[31:2], pc, bus.imem_rdata[1:0] != INSTR_LEN_32};
      state_nxt = state == DRAIN ? (bus.imem_ack ? RUN : DRAIN)
                : (bus.redirect && bus.imem_req && !bus.imem_ack ? DRAIN : RUN);
      pc_nxt = bus.redirect ? {bus.redirect_pc[XLEN-1:2], 2'b00} : push ? pc + XLEN'(4) : pc;
      bus.instr_valid = !empty;
      bus.instr_out = empty ? last.instr : head.instr;
      bus.pc_out = empty ? last.pc : head.pc;
      bus.instr_illegal = empty ? last.illegal : head.illegal;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= RUN;
         pc <= RESET_VECTOR;
         drain_addr <= RESET_VECTOR;
         last <= '0;
      end else begin
         state <= state_nxt;
         pc <= pc_nxt;
         if (state == RUN) drain_addr <= pc;
         if (!empty) last <= head;
      end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; sits directly upstream of the integer decode unit.
- Generates sequential PCs, issues word reads on the instruction-memory request/ack port, and buffers returned instructions with their PCs in a small queue.
- Presents queue-head instruction bits [31:2] plus PC to decode over a valid/ready handshake.
- Redirects the PC on taken jump/branch, flushing queued and in-flight fetches.

Parameters:
XLEN, 32, PC / address width (32 or 64)
DEPTH, 2, fetch queue entries; power of two, >=2
RESET_VECTOR, 0, PC fetched first after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request; held until imem_ack
imem_addr  out  XLEN  word-aligned fetch address; stable while imem_req high
imem_ack  in  1  request complete; imem_rdata valid this cycle; may be high in same cycle imem_req rises
imem_rdata  in  32  instruction word
redirect  in  1  taken jump/branch from execute; single-cycle pulse
redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0)
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head
instr_out  out  30  head instruction bits [31:2], to decode instr_in
pc_out  out  XLEN  PC of head instruction
instr_illegal  out  1  head word had bits [1:0] != 2'b11 (compressed/illegal)

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_VECTOR; queue empty; state RUN.
  - imem_req=0, instr_valid=0, instr_out=0, pc_out=0, instr_illegal=0.
- First cycle after release: imem_req=1, imem_addr=RESET_VECTOR.
- States:
  - RUN: normal fetch.
  - DRAIN: an in-flight response must be discarded.
- RUN:
  - imem_req = (count + 0) < DEPTH; no pop bypass.
  - imem_addr = pc.
  - On imem_ack: write {imem_rdata[31:2], pc, imem_rdata[1:0]!=2'b11} to queue tail; pc += 4.
  - Zero-wait memory (ack every cycle) sustains 1 instruction/cycle with DEPTH>=2.
- Pop: instr_valid && instr_ready. Head advances next edge. Simultaneous push and pop is legal at any count; count unchanged.
- Full (count==DEPTH): imem_req low; no new request until a pop.
- Empty: instr_valid low; instr_out/pc_out hold the last value (don't-care to decode).
- Redirect (highest priority), at the edge:
  - Queue flushed; count=0; the cycle's pop and push are ignored.
  - pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - If imem_req high and imem_ack high the same cycle: response dropped; stay RUN.
  - If imem_req high and imem_ack low: go to DRAIN.
  - instr_valid=0 in the cycle after redirect.
- DRAIN:
  - imem_req stays 1 and imem_addr stays the old address; no protocol violation.
  - On imem_ack: data discarded, no push; next state RUN; new-PC request starts the following cycle.
  - A further redirect in DRAIN updates pc only; state stays DRAIN.
- Arithmetic: pc increment modulo 2^XLEN; wrap from all-ones word to 0 is silent.
- instr_illegal is forwarded only; fetch continues normally.
- Reset asserted mid-request: the outstanding request is abandoned. The memory side must tolerate imem_req dropping without ack under reset.

Decomposition:
- Shared package ifu_pkg:
  - typedef fetch_entry_t {instr[31:2], pc[XLEN-1:0], illegal}.
  - enum fetch_state_t {RUN, DRAIN}.
  - constant INSTR_LEN_32 = 2'b11.
- One sub-module, fetch_queue: parameterised synchronous FIFO (DEPTH, entry type) with push, pop, flush (flush priority), full, empty, count.
  - Pointers wrap by power-of-two width; one extra count bit.
- ifu_fetch holds the PC register, state machine and request logic.

Test Plan:
- Reset, RESET_VECTOR=0x100, ack same cycle every request, ready=1 -> imem_addr 0x100,0x104,0x108 on consecutive cycles; instr_valid from 2nd cycle; pc_out follows one cycle behind.
- ready=0, ack always -> exactly 2 entries accepted (0x100, 0x104), imem_req low while full. Raise ready -> fetch of 0x108 resumes the next cycle.
- Request to 0x104 pending with ack delayed 3 cycles; redirect to 0x200 -> imem_addr holds 0x104 until ack; that data is not queued; next request 0x200; first valid pc_out=0x200.
- Redirect coincident with pop and with ack of 0x108 -> queue empty next cycle, 0x108 word dropped, next imem_addr=redirect_pc.
- imem_rdata=0x00004501 (compressed) -> instr_illegal=1, instr_out=0x00001140, pc advances by 4.
- pc=0xFFFFFFFC, XLEN=32 -> the next request wraps to address 0x0.
